// File: rtl/tile_metrics_monitor.sv
// tile_metrics_monitor: windowed statistics over tile metric samples.
// Accumulates 2^WINDOW_LOG2 valid samples per window, then publishes averages,
// peak power and efficiency-grade min/max as snapshots behind a CSR port.
// Tracks a sticky over-power alarm independently of the window enable.
//
// Ports:
//   clk, reset (async, active-low)
//   sample_valid + phys/eff/skipped ops rates, power (mW), grade, active PEs
//   csr_valid/csr_write/csr_addr/csr_wdata -> csr_rdata/csr_ready (1-cycle later)
//   window_done  : one-cycle pulse aligned with updated snapshot registers
//   power_alarm  : sticky over-power alarm, W1C via STATUS bit 0
module tile_metrics_monitor #(
  parameter int unsigned WINDOW_LOG2   = 8,
  parameter int unsigned ALARM_PERSIST = 4,
  parameter logic [15:0] THRESH_RESET  = 16'd5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [31:0] phys_ops_per_second,
  input  logic [31:0] eff_ops_per_second,
  input  logic [31:0] skipped_phys_ops_per_second,
  input  logic [15:0] power_consumption_mw,
  input  logic [3:0]  efficiency_grade,
  input  logic [15:0] active_pe_count,
  input  logic        csr_valid,
  input  logic        csr_write,
  input  logic [7:0]  csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_ready,
  output logic        window_done,
  output logic        power_alarm
);

  localparam int unsigned OPS_ACC_W = 32 + WINDOW_LOG2;
  localparam int unsigned HW_ACC_W  = 16 + WINDOW_LOG2;
  localparam int unsigned CNT_W     = WINDOW_LOG2;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_PHYS    = 8'h08;
  localparam logic [7:0] ADDR_EFF     = 8'h0C;
  localparam logic [7:0] ADDR_SKIP    = 8'h10;
  localparam logic [7:0] ADDR_POWER   = 8'h14;
  localparam logic [7:0] ADDR_GRADE   = 8'h18;
  localparam logic [7:0] ADDR_THRESH  = 8'h1C;
  localparam logic [7:0] ADDR_WINCNT  = 8'h20;

  typedef enum logic [1:0] {IDLE, RUN, LATCH} state_t;

  state_t state_q, state_d;

  logic                 enable_q;
  logic [15:0]          thresh_q;
  logic [7:0]           persist_q, persist_d;

  logic [OPS_ACC_W-1:0] acc_phys_q, acc_eff_q, acc_skip_q;
  logic [HW_ACC_W-1:0]  acc_pow_q, acc_pe_q;
  logic [15:0]          peak_q;
  logic [3:0]           gmin_q, gmax_q;
  logic [CNT_W-1:0]     sample_cnt_q;

  logic [31:0]          snap_phys_q, snap_eff_q, snap_skip_q, window_count_q;
  logic [15:0]          snap_pow_q, snap_peak_q, snap_pe_q;
  logic [3:0]           snap_gmin_q, snap_gmax_q;
  logic                 snap_valid_q;

  logic csr_wr, csr_rd, clear, alarm_w1c;
  logic accum, wrap, in_latch, over, alarm_set;
  logic [31:0] rd_data;
  logic unused_wdata;

  assign unused_wdata = ^csr_wdata[31:16];

  // Request decode
  assign csr_wr    = csr_valid & csr_write;
  assign csr_rd    = csr_valid & ~csr_write;
  assign clear     = csr_wr & (csr_addr == ADDR_CTRL) & csr_wdata[1];
  assign alarm_w1c = csr_wr & (csr_addr == ADDR_STATUS) & csr_wdata[0];

  // A sample is taken in RUN and also in LATCH (it opens the next window)
  assign in_latch = (state_q == LATCH);
  assign accum    = sample_valid & (state_q != IDLE);
  // Clear on the closing sample suppresses the window close
  assign wrap     = accum & (sample_cnt_q == '1) & ~clear;

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_q) state_d = RUN;
      RUN: begin
        if (wrap)           state_d = LATCH;
        else if (!enable_q) state_d = IDLE;
      end
      LATCH:   state_d = enable_q ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Over-power persistence counter and alarm set condition
  always_comb begin
    over      = sample_valid & (power_consumption_mw > thresh_q);
    persist_d = persist_q;
    if (sample_valid) begin
      if (over) persist_d = (persist_q == 8'hFF) ? 8'hFF : persist_q + 8'd1;
      else      persist_d = 8'd0;
    end
    alarm_set = over & (persist_d >= 8'(ALARM_PERSIST));
  end

  // Alarm state; set beats a coincident W1C
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      persist_q   <= 8'd0;
      power_alarm <= 1'b0;
    end else begin
      persist_q <= persist_d;
      if (alarm_set)      power_alarm <= 1'b1;
      else if (alarm_w1c) power_alarm <= 1'b0;
    end
  end

  // Control registers and CSR response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q  <= 1'b0;
      thresh_q  <= THRESH_RESET;
      csr_ready <= 1'b0;
      csr_rdata <= 32'd0;
    end else begin
      if (csr_wr && csr_addr == ADDR_CTRL)   enable_q <= csr_wdata[0];
      if (csr_wr && csr_addr == ADDR_THRESH) thresh_q <= csr_wdata[15:0];
      csr_ready <= csr_valid;
      csr_rdata <= csr_rd ? rd_data : 32'd0;
    end
  end

  // Read mux
  always_comb begin
    rd_data = 32'd0;
    case (csr_addr)
      ADDR_CTRL:   rd_data = {31'd0, enable_q};
      ADDR_STATUS: rd_data = {16'd0, 8'(sample_cnt_q), 6'd0, snap_valid_q, power_alarm};
      ADDR_PHYS:   rd_data = snap_phys_q;
      ADDR_EFF:    rd_data = snap_eff_q;
      ADDR_SKIP:   rd_data = snap_skip_q;
      ADDR_POWER:  rd_data = {snap_peak_q, snap_pow_q};
      ADDR_GRADE:  rd_data = {snap_pe_q, 8'd0, snap_gmax_q, snap_gmin_q};
      ADDR_THRESH: rd_data = {16'd0, thresh_q};
      ADDR_WINCNT: rd_data = window_count_q;
      default:     rd_data = 32'd0;
    endcase
  end

  // Window accumulators; LATCH restarts them from the coincident sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_phys_q   <= '0;
      acc_eff_q    <= '0;
      acc_skip_q   <= '0;
      acc_pow_q    <= '0;
      acc_pe_q     <= '0;
      peak_q       <= 16'd0;
      gmin_q       <= 4'hF;
      gmax_q       <= 4'h0;
      sample_cnt_q <= '0;
    end else if (clear) begin
      acc_phys_q   <= '0;
      acc_eff_q    <= '0;
      acc_skip_q   <= '0;
      acc_pow_q    <= '0;
      acc_pe_q     <= '0;
      peak_q       <= 16'd0;
      gmin_q       <= 4'hF;
      gmax_q       <= 4'h0;
      sample_cnt_q <= '0;
    end else if (in_latch) begin
      acc_phys_q   <= accum ? OPS_ACC_W'(phys_ops_per_second)         : '0;
      acc_eff_q    <= accum ? OPS_ACC_W'(eff_ops_per_second)          : '0;
      acc_skip_q   <= accum ? OPS_ACC_W'(skipped_phys_ops_per_second) : '0;
      acc_pow_q    <= accum ? HW_ACC_W'(power_consumption_mw)         : '0;
      acc_pe_q     <= accum ? HW_ACC_W'(active_pe_count)              : '0;
      peak_q       <= accum ? power_consumption_mw : 16'd0;
      gmin_q       <= accum ? efficiency_grade     : 4'hF;
      gmax_q       <= accum ? efficiency_grade     : 4'h0;
      sample_cnt_q <= accum ? CNT_W'(1)            : '0;
    end else if (accum) begin
      acc_phys_q   <= acc_phys_q + OPS_ACC_W'(phys_ops_per_second);
      acc_eff_q    <= acc_eff_q  + OPS_ACC_W'(eff_ops_per_second);
      acc_skip_q   <= acc_skip_q + OPS_ACC_W'(skipped_phys_ops_per_second);
      acc_pow_q    <= acc_pow_q  + HW_ACC_W'(power_consumption_mw);
      acc_pe_q     <= acc_pe_q   + HW_ACC_W'(active_pe_count);
      if (power_consumption_mw > peak_q) peak_q <= power_consumption_mw;
      if (efficiency_grade < gmin_q)     gmin_q <= efficiency_grade;
      if (efficiency_grade > gmax_q)     gmax_q <= efficiency_grade;
      sample_cnt_q <= sample_cnt_q + CNT_W'(1);
    end
  end

  // Snapshot publish; clear in the LATCH cycle cancels it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_phys_q    <= 32'd0;
      snap_eff_q     <= 32'd0;
      snap_skip_q    <= 32'd0;
      snap_pow_q     <= 16'd0;
      snap_peak_q    <= 16'd0;
      snap_pe_q      <= 16'd0;
      snap_gmin_q    <= 4'd0;
      snap_gmax_q    <= 4'd0;
      snap_valid_q   <= 1'b0;
      window_count_q <= 32'd0;
      window_done    <= 1'b0;
    end else begin
      window_done <= in_latch & ~clear;
      if (clear) begin
        snap_phys_q    <= 32'd0;
        snap_eff_q     <= 32'd0;
        snap_skip_q    <= 32'd0;
        snap_pow_q     <= 16'd0;
        snap_peak_q    <= 16'd0;
        snap_pe_q      <= 16'd0;
        snap_gmin_q    <= 4'd0;
        snap_gmax_q    <= 4'd0;
        snap_valid_q   <= 1'b0;
        window_count_q <= 32'd0;
      end else if (in_latch) begin
        snap_phys_q    <= 32'(acc_phys_q >> WINDOW_LOG2);
        snap_eff_q     <= 32'(acc_eff_q  >> WINDOW_LOG2);
        snap_skip_q    <= 32'(acc_skip_q >> WINDOW_LOG2);
        snap_pow_q     <= 16'(acc_pow_q  >> WINDOW_LOG2);
        snap_pe_q      <= 16'(acc_pe_q   >> WINDOW_LOG2);
        snap_peak_q    <= peak_q;
        snap_gmin_q    <= gmin_q;
        snap_gmax_q    <= gmax_q;
        snap_valid_q   <= 1'b1;
        window_count_q <= window_count_q + 32'd1;
      end
    end
  end

endmodule
